mul_repadd_unit: RTL and testbench
==================================

Name: mul_repadd_unit

Overview:
- Self-contained unsigned multiplier that computes product = a * b by repeated addition.
- Integrates the multiplicand register, accumulator, down-counter, zero-detect and the sequencing FSM in one block.
- Parametrised in operand width; exposes a start/busy/done handshake to the surrounding control logic.
- Successor to the fixed 16-bit datapath-plus-external-controller arrangement.

Parameters:
- WIDTH, 16, operand width in bits for a and b; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when state = IDLE
- abort  input  1  synchronous cancel of an in-flight operation
- a  input  WIDTH  multiplicand, sampled on the accept edge
- b  input  WIDTH  multiplier (repeat count), sampled on the accept edge
- busy  output  1  high whenever state != IDLE
- done  output  1  single-cycle pulse when product is updated
- product  output  2*WIDTH  registered result, held until the next completion
- cycles  output  WIDTH  number of additions performed in the last completed operation

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, product=0, cycles=0; internal A, B, P, iteration count cleared.
- FSM states are IDLE, ACC and DONE.
- IDLE: start=1 on a clock edge is the accept edge.
  - A<=a, B<=b, P<=0, iteration count<=0.
  - Next state is ACC.
  - start=0 keeps the FSM in IDLE.
- ACC, B!=0: P<=P+A (2*WIDTH-bit add, A zero-extended, no overflow possible); B<=B-1; iteration count+1; stay in ACC.
- ACC, B==0:
  - product<=P, cycles<=iteration count.
  - done is high for the following cycle.
  - Next state is DONE.
- DONE: lasts exactly one cycle (done=1, busy=1), then IDLE.
- Latency: done is asserted b+2 cycles after the accept edge.
  - b=0: done in the 2nd cycle after accept; product=0, cycles=0.
  - a=0, b=N: N additions of zero; product=0, cycles=N.
- start while busy=1, including the DONE cycle, is ignored: no queueing and no effect on operands.
- Back-to-back operation: start asserted in the cycle after the DONE cycle is accepted, so the minimum issue interval is b+3 cycles.
- abort=1 in ACC:
  - Next state is IDLE; done is not pulsed.
  - product and cycles keep their previous values.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the ACC arithmetic on the same edge.
- abort and start both high in IDLE: start is accepted (abort ignored).
- Reset mid-operation: immediate return to the reset values above; no done pulse.
- Operands a and b may change freely after the accept edge without affecting the result.
- Maximum operation: a=b=2^WIDTH-1 gives product=(2^WIDTH-1)^2, fits in 2*WIDTH bits, no wrap.

Optional Feature:
- Macro: MUL_REPADD_SWAP_EN.
- Defined:
  - On the accept edge the smaller operand is loaded into B and the larger into A.
  - Latency becomes min(a,b)+2 cycles; cycles reports min(a,b).
  - Equal operands load a into A.
- Not defined: no comparison logic; A<=a, B<=b as above; latency is b+2.
- Product value is identical in both builds.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release with start=0 for 10 cycles -> busy=0, done=0, product=0, cycles=0 throughout.
- Basic multiply, WIDTH=16: a=7, b=5, start 1 cycle -> busy high; done pulse exactly 7 cycles after the accept edge; product=35, cycles=5; product holds 35 for 20 further idle cycles.
- Zero boundaries:
  - a=9, b=0 -> done 2 cycles after accept, product=0, cycles=0.
  - a=0, b=4 -> product=0, cycles=4.
- Abort and ignored start:
  - a=3, b=10 accepted, abort pulsed 4 cycles later -> no done, busy low next cycle, product retains previous value 35.
  - start pulsed with a=2, b=2 while busy -> ignored; result of the original operation is unaffected.
- Swap, MUL_REPADD_SWAP_EN defined: a=3, b=200 -> done 5 cycles after accept, product=600, cycles=3. Same stimulus without the macro -> done 202 cycles after accept, product=600, cycles=200.
- Max width and async reset: WIDTH=8, a=255, b=255 -> product=65025. Rerun with rst_n dropped mid-ACC (between clock edges) -> outputs reset to 0 immediately and no done pulse.

Source files
------------

// File: rtl/mul_repadd_unit.sv
// ---------------------------------------------------------------------------
// mul_repadd_unit : unsigned multiply by repeated addition (start/busy/done).
// Optional MUL_REPADD_SWAP_EN loads the smaller operand as the repeat count.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_repadd_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_ld_a;
  logic [WIDTH-1:0]   w_ld_b;

`ifdef MUL_REPADD_SWAP_EN
  // Smaller operand becomes the repeat count; ties keep a as the multiplicand.
  logic w_swap;
  assign w_swap = (b > a);
  assign w_ld_a = w_swap ? b : a;
  assign w_ld_b = w_swap ? a : b;
`else
  assign w_ld_a = a;
  assign w_ld_b = b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cycles  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= w_ld_a;
            r_b     <= w_ld_b;
            r_p     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          // Abort wins over both the add and the completion on the same edge.
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_b != '0) begin
            r_p   <= r_p + {{WIDTH{1'b0}}, r_a};
            r_b   <= r_b - 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            product <= r_p;
            cycles  <= r_cnt;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_repadd_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_repadd_unit : randomized self-checking bench, WIDTH=16 and WIDTH=8.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_repadd_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] cycles;

  logic        rst_n8 = 1'b0;
  logic        start8 = 1'b0;
  logic        abort8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;
  logic [7:0]  cycles8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_prod = '0;
  logic [15:0] last_cyc = '0;

  mul_repadd_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .cycles(cycles)
  );

  mul_repadd_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .abort(abort8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .cycles(cycles8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: number of additions the unit performs for given operands.
  function automatic logic [15:0] exp_iters(input logic [15:0] ia, input logic [15:0] ib);
`ifdef MUL_REPADD_SWAP_EN
    return (ia < ib) ? ia : ib;
`else
    return ib;
`endif
  endfunction

  function automatic logic [31:0] exp_prod(input logic [15:0] ia, input logic [15:0] ib);
    return {16'd0, ia} * {16'd0, ib};
  endfunction

  // Drives one accept cycle; returns at the sample point of cycle 1 after accept.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 1;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done8(input int limit, output int n);
    n = 1;
    while (done8 !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst_n8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_n8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, product, cycles} !== 50'd0) begin
        errors++;
        $display("FAIL reset_idle16 cyc%0d: busy=%b done=%b product=%0d cycles=%0d, expected all 0",
                 i, busy, done, product, cycles);
      end
      checks++;
      if ({busy8, done8, product8, cycles8} !== 26'd0) begin
        errors++;
        $display("FAIL reset_idle8 cyc%0d: busy=%b done=%b product=%0d cycles=%0d, expected all 0",
                 i, busy8, done8, product8, cycles8);
      end
    end
  endtask

  task automatic test_basic;
    int n, lat;
    lat = int'(exp_iters(16'd7, 16'd5)) + 2;
    issue(16'd7, 16'd5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_done(lat + 10, n);
    checks++;
    if (done !== 1'b1 || n != lat) begin
      errors++; $display("FAIL basic_latency: done=%b at cycle %0d, expected at cycle %0d", done, n, lat);
    end
    checks++;
    if (product !== 32'd35 || cycles !== exp_iters(16'd7, 16'd5)) begin
      errors++; $display("FAIL basic_result: product=%0d cycles=%0d, expected 35/%0d",
                         product, cycles, exp_iters(16'd7, 16'd5));
    end
    last_prod = 32'd35; last_cyc = exp_iters(16'd7, 16'd5);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: done=%b busy=%b, expected 0/0", done, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (product !== 32'd35 || done !== 1'b0) begin
        errors++; $display("FAIL basic_hold cyc%0d: product=%0d done=%b, expected 35/0", i, product, done);
      end
    end
  endtask

  task automatic test_abort;
    bit seen_done;
    issue(16'd3, 16'd10);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_busy: busy=%b done=%b, expected 0/0", busy, done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++; $display("FAIL abort_no_done: done pulse seen=1, expected 0");
    end
    checks++;
    if (product !== last_prod || cycles !== last_cyc) begin
      errors++; $display("FAIL abort_retain: product=%0d cycles=%0d, expected %0d/%0d",
                         product, cycles, last_prod, last_cyc);
    end
  endtask

  task automatic test_zero;
    logic [15:0] ta [2];
    logic [15:0] tb [2];
    int n, lat;
    ta[0] = 16'd9; tb[0] = 16'd0;
    ta[1] = 16'd0; tb[1] = 16'd4;
    for (int k = 0; k < 2; k++) begin
      lat = int'(exp_iters(ta[k], tb[k])) + 2;
      issue(ta[k], tb[k]);
      wait_done(lat + 10, n);
      checks++;
      if (done !== 1'b1 || n != lat) begin
        errors++; $display("FAIL zero%0d_latency: done=%b at cycle %0d, expected at cycle %0d", k, done, n, lat);
      end
      checks++;
      if (product !== 32'd0 || cycles !== exp_iters(ta[k], tb[k])) begin
        errors++; $display("FAIL zero%0d_result: product=%0d cycles=%0d, expected 0/%0d",
                           k, product, cycles, exp_iters(ta[k], tb[k]));
      end
      @(negedge clk);
    end
    last_prod = 32'd0; last_cyc = exp_iters(ta[1], tb[1]);
  endtask

  task automatic test_ignored_start;
    int n, lat;
    lat = int'(exp_iters(16'd11, 16'd6)) + 2;
    abort = 1'b1;
    issue(16'd11, 16'd6);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_with_abort: busy=%b expected 1", busy);
    end
    // Hold start with different operands through ACC and the DONE cycle.
    start = 1'b1; a = 16'd2; b = 16'd2;
    n = 1;
    while (done !== 1'b1 && n < lat + 10) begin
      @(negedge clk);
      n++;
      a = 16'($urandom_range(0, 3)); b = 16'($urandom_range(0, 3));
    end
    checks++;
    if (done !== 1'b1 || n != lat) begin
      errors++; $display("FAIL ignored_latency: done=%b at cycle %0d, expected at cycle %0d", done, n, lat);
    end
    checks++;
    if (product !== 32'd66 || cycles !== exp_iters(16'd11, 16'd6)) begin
      errors++; $display("FAIL ignored_result: product=%0d cycles=%0d, expected 66/%0d",
                         product, cycles, exp_iters(16'd11, 16'd6));
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ignored_in_done: busy=%b after DONE, expected 0", busy);
    end
    last_prod = 32'd66; last_cyc = exp_iters(16'd11, 16'd6);
  endtask

  task automatic test_back_to_back;
    logic [15:0] ia, ib;
    int n, lat;
    for (int i = 0; i < 10; i++) begin
      ia = 16'($urandom);
      ib = 16'($urandom_range(0, 24));
      lat = int'(exp_iters(ia, ib)) + 2;
      issue(ia, ib);
      wait_done(lat + 10, n);
      checks++;
      if (done !== 1'b1 || n != lat) begin
        errors++; $display("FAIL b2b%0d_latency: done=%b at cycle %0d, expected at cycle %0d", i, done, n, lat);
      end
      checks++;
      if (product !== exp_prod(ia, ib) || cycles !== exp_iters(ia, ib)) begin
        errors++; $display("FAIL b2b%0d_result a=%0d b=%0d: product=%0d cycles=%0d, expected %0d/%0d",
                           i, ia, ib, product, cycles, exp_prod(ia, ib), exp_iters(ia, ib));
      end
      // Next iteration issues in the cycle right after DONE.
      @(negedge clk);
    end
  endtask

  task automatic test_swap;
    int n, lat;
    lat = int'(exp_iters(16'd3, 16'd200)) + 2;
    issue(16'd3, 16'd200);
    wait_done(lat + 10, n);
    checks++;
    if (done !== 1'b1 || n != lat) begin
      errors++; $display("FAIL swap_latency: done=%b at cycle %0d, expected at cycle %0d", done, n, lat);
    end
    checks++;
    if (product !== 32'd600 || cycles !== exp_iters(16'd3, 16'd200)) begin
      errors++; $display("FAIL swap_result: product=%0d cycles=%0d, expected 600/%0d",
                         product, cycles, exp_iters(16'd3, 16'd200));
    end
    @(negedge clk);
  endtask

  task automatic test_max8_reset;
    int n;
    bit seen_done;
    issue8(8'd255, 8'd255);
    wait_done8(300, n);
    checks++;
    if (done8 !== 1'b1 || n != 257) begin
      errors++; $display("FAIL max8_latency: done=%b at cycle %0d, expected at cycle 257", done8, n);
    end
    checks++;
    if (product8 !== 16'd65025 || cycles8 !== 8'd255) begin
      errors++; $display("FAIL max8_result: product=%0d cycles=%0d, expected 65025/255", product8, cycles8);
    end
    @(negedge clk);
    issue8(8'd255, 8'd255);
    repeat (50) @(negedge clk);
    #2 rst_n8 = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, product8, cycles8} !== 26'd0) begin
      errors++; $display("FAIL max8_async_reset: busy=%b done=%b product=%0d cycles=%0d, expected all 0",
                         busy8, done8, product8, cycles8);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done8 === 1'b1) seen_done = 1'b1;
    end
    rst_n8 = 1'b1;
    repeat (260) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++; $display("FAIL max8_no_done_after_reset: activity seen=1, expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_zero();
    test_ignored_start();
    test_back_to_back();
    test_swap();
    test_max8_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
